dither_packer: RTL and testbench
================================

# dither_packer

Downstream consumer of the 240x320 dithered frame BRAM. On a start pulse it walks the frame in raster order and reads 7-bit dithered pixels through the BRAM's 2-cycle read port. It thresholds each pixel to 1 bit and packs 8 pixels per byte, MSB = leftmost. Bytes go out over a valid/ready stream to the printer/UART sender used by the photobooth SEND state.

## Interface
Parameters:
- H_PIXELS, 240, pixels per row; must be a multiple of 8
- V_PIXELS, 320, rows per frame
- ADDR_W, 17, BRAM address width
- PIX_W, 7, dithered pixel width
- RD_LAT, 2, BRAM read latency in cycles

Ports:
- clk_in  in  1  system clock (65 MHz)
- rst_in  in  1  synchronous, active-high reset
- start_in  in  1  one-cycle pulse that starts a frame transfer; ignored while busy_out=1
- threshold_in  in  PIX_W  pixel < threshold gives dot bit 1; sampled on accepted start
- invert_in  in  1  XORs every dot bit; sampled on accepted start
- mem_addr_out  out  ADDR_W  BRAM read address
- mem_data_in  in  PIX_W  BRAM read data, valid RD_LAT cycles after the address
- byte_out  out  8  packed byte
- byte_valid_out  out  1  byte_out holds a valid byte
- byte_ready_in  in  1  consumer accepts the byte
- row_last_out  out  1  qualifies byte_out as the last byte of a row
- frame_last_out  out  1  qualifies byte_out as the last byte of the frame
- busy_out  out  1  transfer in progress
- done_out  out  1  one-cycle pulse when the transfer ends

## Operation
- States: IDLE, FETCH, WAIT_DATA, HOLD.
- IDLE → FETCH on start_in. On that transition: latch threshold_in and invert_in, clear the pixel address to 0, and assert busy_out.
- FETCH: issue 8 consecutive addresses, one per cycle, then go to WAIT_DATA.
- WAIT_DATA: shift the returning bits into the staging register. When the 8th bit lands, the staging byte is full. If the output register is empty, or is being accepted in the same cycle, move the byte there. Otherwise go to HOLD.
- HOLD: keep the staging byte until the output register frees, then transfer it.
- After each transfer: if bytes remain, go to FETCH; else wait for the final handshake, pulse done_out, and go to IDLE.
- Dot bit = (pixel < threshold) ^ invert. The first pixel of a group goes to bit 7.
- Address sequence is linear 0 .. H_PIXELS*V_PIXELS-1 (76799). It never wraps within a frame.
- Byte counter runs 0..9599.
  - row_last_out = 1 when byte index mod (H_PIXELS/8) = 29.
  - frame_last_out = 1 for byte 9599; row_last_out is also 1 on that byte.
- Output handshake follows standard valid/ready:
  - A transfer occurs on a cycle with valid & ready.
  - byte_out, row_last_out and frame_last_out hold stable while valid & !ready.
  - valid never drops without a transfer.
- start_in while busy is ignored; it is neither queued nor a restart.
- rst_in at any time returns to IDLE and discards in-flight reads and the staging byte. The next frame after reset starts at address 0.
- Reset values: mem_addr_out=0, byte_out=0, byte_valid_out=0, row_last_out=0, frame_last_out=0, busy_out=0, done_out=0.

## Timing
- With start_in at cycle 0:
  - addresses 0..7 are driven on cycles 1..8
  - data arrives on cycles 3..10
  - byte_valid_out first goes high on cycle 11
- Sustained throughput with byte_ready_in held high: one byte per 10 cycles (8 issue + RD_LAT). A full frame takes about 96,000 cycles.
- At most two bytes are ever buffered (output register + staging). Address issue never outruns staging space, so no read data is lost under any ready pattern.
- done_out pulses the cycle after the frame_last_out handshake. busy_out falls in the same cycle.
- A start_in in the same cycle as done_out is ignored. A start_in one cycle later is accepted.

## Structure
- Shared package photobooth_pkg holds:
  - FRAME_W=240, FRAME_H=320, FRAME_PIXELS, BYTES_PER_ROW=30, BYTES_PER_FRAME=9600
  - the dither pixel type (logic [6:0])
  - the state enum
- One natural sub-module: bit_packer. It is an 8-bit MSB-first shift register with load/full flag, fed by a RD_LAT-deep valid shift line that tracks in-flight reads.

## Test plan
- BRAM model filled with all 0s, threshold 64, invert 0, ready always 1 → 9600 bytes of 0xFF. Bytes 29, 59, … carry row_last_out. Byte 9599 carries frame_last_out. done_out pulses once.
- Alternating pixel pattern 0,127 → every byte 0xAA. Same pattern with invert_in=1 → every byte 0x55.
- Random 0/1 byte_ready_in → byte sequence identical to the ready-always run, no byte dropped or duplicated, and byte_out stable during every stall.
- start_in → first byte_valid_out on cycle 11. With ready high, the steady spacing between bytes is 10 cycles.
- Second start_in mid-frame → ignored, frame completes normally. rst_in at byte 500 → all outputs reach reset values the next cycle. A new start then re-reads from address 0.
- threshold_in changed mid-frame → no effect on the current frame. The new value applies only after the next accepted start.

Source files
------------

// File: rtl/photobooth_pkg.sv
// photobooth_pkg: frame geometry, dither pixel type and packer states
// shared by the photobooth SEND-path blocks.
package photobooth_pkg;
  localparam int FRAME_W = 240;
  localparam int FRAME_H = 320;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int BYTES_PER_ROW = FRAME_W / 8;
  localparam int BYTES_PER_FRAME = FRAME_PIXELS / 8;

  typedef logic [6:0] dpix_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_HOLD
  } pk_state_e;
endpackage

// File: rtl/dither_packer_bit_packer.sv
// bit_packer: MSB-first 8-bit staging shift register fed by a
// valid line that tracks reads in flight through the BRAM.
module bit_packer #(
  parameter int RD_LAT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_i,
  input  logic       bit_i,
  input  logic       take_i,
  output logic       land_o,
  output logic       full_o,
  output logic [7:0] byte_o,
  output logic [7:0] next_o
);
  logic [RD_LAT-1:0] vld_q;
  logic [7:0]        sr_q;
  logic [3:0]        cnt_q;
  logic              bit_vld;

  assign bit_vld = vld_q[RD_LAT-1];
  assign next_o  = {sr_q[6:0], bit_i};
  assign byte_o  = sr_q;
  assign full_o  = cnt_q[3];
  assign land_o  = bit_vld && (cnt_q == 4'd7);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q[0] <= issue_i;
      for (int i = 1; i < RD_LAT; i++)
        vld_q[i] <= vld_q[i-1];
      // a take coincides with the 8th bit; the top loads next_o
      if (take_i)
        cnt_q <= '0;
      else if (bit_vld) begin
        sr_q  <= next_o;
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end
endmodule

// File: rtl/dither_packer.sv
// dither_packer: reads the dithered frame in raster order,
// thresholds to 1 bpp and streams packed bytes over valid/ready.
module dither_packer
  import photobooth_pkg::*;
#(
  parameter int H_PIXELS = FRAME_W,
  parameter int V_PIXELS = FRAME_H,
  parameter int ADDR_W   = 17,
  parameter int PIX_W    = 7,
  parameter int RD_LAT   = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [PIX_W-1:0]  threshold_in,
  input  logic              invert_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [PIX_W-1:0]  mem_data_in,
  output logic [7:0]        byte_out,
  output logic              byte_valid_out,
  input  logic              byte_ready_in,
  output logic              row_last_out,
  output logic              frame_last_out,
  output logic              busy_out,
  output logic              done_out
);
  localparam int BPR = H_PIXELS / 8;
  localparam int BPF = (H_PIXELS * V_PIXELS) / 8;
  localparam int BW  = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int CW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [BW-1:0] BPF_M1 = BW'(BPF - 1);
  localparam logic [CW-1:0] BPR_M1 = CW'(BPR - 1);

  pk_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        fcnt_q;
  logic [BW-1:0]     bidx_q;
  logic [CW-1:0]     col_q;
  logic [PIX_W-1:0]  thr_q;
  logic              inv_q;
  logic              ovld_q, orow_q, oframe_q, done_q;
  logic [7:0]        obyte_q;

  logic start_ok, issue, load, take;
  logic out_free, fin, more, dot;
  logic pk_land, pk_full;
  logic [7:0] pk_byte, pk_next, ld_byte;

  assign dot      = (mem_data_in < thr_q) ^ inv_q;
  assign out_free = !ovld_q || byte_ready_in;
  assign fin      = ovld_q && byte_ready_in && oframe_q;
  assign more     = (bidx_q != BPF_M1);
  assign ld_byte  = (state_q == S_WAIT_DATA) ? pk_next : pk_byte;

  bit_packer #(.RD_LAT(RD_LAT)) u_pack (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .issue_i(issue),
    .bit_i  (dot),
    .take_i (take),
    .land_o (pk_land),
    .full_o (pk_full),
    .byte_o (pk_byte),
    .next_o (pk_next)
  );

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    issue    = 1'b0;
    load     = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // start in the done cycle is dropped
        if (start_in && !done_q) begin
          start_ok = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        issue = 1'b1;
        if (fcnt_q == 3'd7)
          state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (pk_land) begin
          if (out_free) begin
            load    = 1'b1;
            take    = 1'b1;
            state_d = more ? S_FETCH : S_HOLD;
          end else
            state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pk_full && out_free) begin
          load    = 1'b1;
          take    = 1'b1;
          state_d = more ? S_FETCH : S_HOLD;
        end
      end
    endcase
    if (fin)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      fcnt_q   <= '0;
      bidx_q   <= '0;
      col_q    <= '0;
      thr_q    <= '0;
      inv_q    <= 1'b0;
      ovld_q   <= 1'b0;
      obyte_q  <= '0;
      orow_q   <= 1'b0;
      oframe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= fin;
      if (start_ok) begin
        thr_q  <= threshold_in;
        inv_q  <= invert_in;
        addr_q <= '0;
        fcnt_q <= '0;
        bidx_q <= '0;
        col_q  <= '0;
      end
      if (issue) begin
        addr_q <= addr_q + 1'b1;
        fcnt_q <= fcnt_q + 3'd1;
      end
      if (load) begin
        obyte_q  <= ld_byte;
        orow_q   <= (col_q == BPR_M1);
        oframe_q <= (bidx_q == BPF_M1);
        bidx_q   <= bidx_q + 1'b1;
        col_q    <= (col_q == BPR_M1) ? '0 : col_q + 1'b1;
        ovld_q   <= 1'b1;
      end else if (ovld_q && byte_ready_in)
        ovld_q <= 1'b0;
    end
  end

  assign mem_addr_out   = addr_q;
  assign byte_out       = obyte_q;
  assign byte_valid_out = ovld_q;
  assign row_last_out   = orow_q;
  assign frame_last_out = oframe_q;
  assign busy_out       = (state_q != S_IDLE);
  assign done_out       = done_q;
endmodule

// File: tb/tb_dither_packer.sv
// tb_dither_packer: random frames through a 2-cycle BRAM model,
// compared byte-by-byte with a pixel-level packing model.
module tb_dither_packer;
  import photobooth_pkg::*;

  localparam int H    = 48;
  localparam int V    = 8;
  localparam int NPIX = H * V;
  localparam int BPR  = H / 8;
  localparam int NB   = NPIX / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  thr_in = '0;
  logic        inv = 1'b0;
  logic [16:0] addr;
  logic [6:0]  mdata;
  logic [7:0]  bout;
  logic        bvalid;
  logic        bready = 1'b1;
  logic        rowl, frml, busy, done;

  always #5 clk = ~clk;

  dither_packer #(
    .H_PIXELS(H), .V_PIXELS(V), .ADDR_W(17),
    .PIX_W(7), .RD_LAT(2)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .threshold_in  (thr_in),
    .invert_in     (inv),
    .mem_addr_out  (addr),
    .mem_data_in   (mdata),
    .byte_out      (bout),
    .byte_valid_out(bvalid),
    .byte_ready_in (bready),
    .row_last_out  (rowl),
    .frame_last_out(frml),
    .busy_out      (busy),
    .done_out      (done)
  );

  dpix_t mem [NPIX];
  dpix_t d1 = '0, d2 = '0;
  always @(posedge clk) begin
    d1 <= (addr < NPIX) ? mem[addr] : '0;
    d2 <= d1;
  end
  assign mdata = d2;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_addr"}, 32'(addr), 0);
    chk({p, "_byte"}, 32'(bout), 0);
    chk({p, "_valid"}, 32'(bvalid), 0);
    chk({p, "_rowl"}, 32'(rowl), 0);
    chk({p, "_frml"}, 32'(frml), 0);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_done"}, 32'(done), 0);
  endtask

  // expected stream: pixel 8k+j lands in bit 7-j of byte k
  logic [7:0] expb [NB];
  function automatic void build(input logic [6:0] t,
                                input logic iv);
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 8; j++)
        expb[k][7-j] = (mem[8*k+j] < t) ^ iv;
  endfunction

  bit   rrand = 1'b0;
  initial forever begin
    @(posedge clk);
    #2;
    bready = rrand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  bit        mon_en = 1'b0;
  int        nrx, ndone, sc, idx;
  int        trise [2];
  bit        pv, stall, last_hs;
  logic [9:0] sv;

  always @(negedge clk) if (mon_en) begin
    idx = cyc - sc;
    if (idx == 1)  chk("addr_cycle1", 32'(addr), 0);
    if (idx == 8)  chk("addr_cycle8", 32'(addr), 7);
    if (idx == 10) chk("valid_cycle10", 32'(bvalid), 0);
    if (bvalid && !pv) begin
      if (trise[0] < 0) trise[0] = idx;
      else if (trise[1] < 0) trise[1] = idx;
    end
    pv = bvalid;
    if (stall)
      chk("stall_hold", {bvalid, bout, rowl, frml},
          {1'b1, sv});
    stall = bvalid && !bready;
    sv = {bout, rowl, frml};
    if (done) begin
      ndone++;
      chk("busy_at_done", 32'(busy), 0);
    end
    if (done || last_hs)
      chk("done_timing", 32'(done), 32'(last_hs));
    last_hs = bvalid && bready && frml;
    if (bvalid && bready) begin
      if (nrx < NB) begin
        chk("byte", 32'(bout), 32'(expb[nrx]));
        chk("row_last", 32'(rowl), 32'((nrx % BPR) == BPR - 1));
        chk("frame_last", 32'(frml), 32'(nrx == NB - 1));
      end else
        chk("extra_byte", nrx, NB - 1);
      nrx++;
    end
  end

  task automatic mon_clear();
    nrx = 0; ndone = 0;
    trise[0] = -1; trise[1] = -1;
    pv = 1'b0; stall = 1'b0; last_hs = 1'b0;
  endtask

  task automatic pulse_start(input logic [6:0] t,
                             input logic iv);
    @(posedge clk);
    #2;
    thr_in = t; inv = iv; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    sc = cyc - 1;
  endtask

  task automatic run_frame(input logic [6:0] t, input logic iv,
                           input bit rr, input bit mid,
                           input bit b2b);
    int n = 0;
    bit ms = 1'b0;
    bit seen = 1'b0;
    build(t, iv);
    mon_clear();
    rrand = rr;
    pulse_start(t, iv);
    mon_en = 1'b1;
    thr_in = t ^ 7'h55;
    inv = ~iv;
    while (n < 4000 && !seen) begin
      @(posedge clk);
      #2;
      start = 1'b0;
      n++;
      if (done) begin
        seen = 1'b1;
        if (b2b) start = 1'b1;
      end else if (mid && !ms && nrx >= 5) begin
        start = 1'b1;
        ms = 1'b1;
      end
    end
    chk("frame_done_seen", 32'(seen), 1);
    if (b2b) begin
      @(posedge clk);
      #2;
      chk("start_on_done_ignored", 32'(busy), 0);
      @(posedge clk);
      #2;
      start = 1'b0;
      chk("start_after_done_taken", 32'(busy), 1);
    end else
      repeat (3) @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("byte_count", nrx, NB);
    chk("done_count", ndone, 1);
    chk("first_valid_cycle", trise[0], 11);
    if (!rr)
      chk("byte_spacing", trise[1] - trise[0], 10);
  endtask

  task automatic reset_mid(input logic [6:0] t);
    int n = 0;
    build(t, 1'b0);
    mon_clear();
    rrand = 1'b1;
    pulse_start(t, 1'b0);
    mon_en = 1'b1;
    while (n < 4000 && nrx < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("reached_byte10", 32'(nrx >= 10), 1);
    rst = 1'b1;
    @(posedge clk);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
  endtask

  initial begin
    logic [6:0] t;
    @(negedge clk);
    chk_reset("por");
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int i = 0; i < NPIX; i++) mem[i] = '0;
    run_frame(7'd64, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NPIX; i++) mem[i] = (i % 2) ? 7'd127 : 7'd0;
    run_frame(7'd64, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(7'd64, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NPIX; i++) mem[i] = 7'($urandom_range(0, 127));
    t = 7'($urandom_range(1, 126));
    run_frame(t, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(t, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(7'($urandom_range(1, 126)), 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(7'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(7'd127, 1'b1, 1'b0, 1'b0, 1'b0);

    reset_mid(7'($urandom_range(1, 126)));
    run_frame(7'($urandom_range(1, 126)), 1'b0, 1'b1, 1'b0, 1'b0);

    run_frame(7'd64, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("endrst");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
